// File: rtl/output_buffer_drain_pkg.sv
// Shared constants and state type for the output result buffer.
package output_buffer_drain_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

endpackage

// File: rtl/output_buffer_mem.sv
// Result register file with per-entry unread flags and overwrite detection.
module output_buffer_mem
    import output_buffer_drain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic [DEPTH-1:0]  entry_valid,
    output logic              overwrite_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_next;
    logic              same_clr;

    assign same_clr = clr_en && (clr_addr == wr_addr);

    // Write-first read: a same-cycle write to the read address is forwarded.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

    // Clear applied before set so a write wins over a same-entry read.
    always_comb begin
        valid_next = entry_valid;
        if (clr_en) valid_next[clr_addr] = 1'b0;
        if (wr_en)  valid_next[wr_addr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            entry_valid   <= '0;
            overwrite_err <= 1'b0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (wr_en && entry_valid[wr_addr] && !same_clr) overwrite_err <= 1'b1;
            entry_valid <= valid_next;
        end
    end

endmodule

// File: rtl/output_buffer_drain.sv
// Result buffer that streams entries 0..N-1 over valid/ready at full rate.
module output_buffer_drain
    import output_buffer_drain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W:0]   drain_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              overwrite_err,
    output logic [DEPTH-1:0]  entry_valid
);

    state_t            state, state_next;
    logic [ADDR_W:0]   count;
    logic              load, finish, clr_en, last;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] rd_data;

    output_buffer_mem u_mem (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (load_addr),
        .rd_data       (rd_data),
        .clr_en        (clr_en),
        .clr_addr      (out_addr),
        .entry_valid   (entry_valid),
        .overwrite_err (overwrite_err)
    );

    assign last = ({1'b0, out_addr} == (count - (ADDR_W+1)'(1)));

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_addr  = '0;
        clr_en     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (drain_start) begin
                    state_next = DRAIN;
                    load       = 1'b1;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    clr_en = 1'b1;
                    if (last) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_addr = out_addr + ADDR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (state == IDLE && drain_start)
                count <= (drain_count == '0) ? (ADDR_W+1)'(DEPTH) : drain_count;
            if (load) begin
                out_data  <= rd_data;
                out_addr  <= load_addr;
                out_valid <= 1'b1;
                busy      <= 1'b1;
            end
            if (finish) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_buffer_drain.sv
// Directed bench for output_buffer_drain with a cycle model and literal checks.
module tb_output_buffer_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        drain_start;
    logic [4:0]  drain_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        busy;
    logic        done;
    logic        overwrite_err;
    logic [15:0] entry_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_buffer_drain dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .drain_start   (drain_start),
        .drain_count   (drain_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .busy          (busy),
        .done          (done),
        .overwrite_err (overwrite_err),
        .entry_valid   (entry_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer contents, unread flags, and the word currently offered.
    logic [31:0] m_mem [16];
    logic [15:0] m_val;
    bit          m_err, m_busy, m_done;
    int          m_n;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    bit          chk_en = 0;

    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic [3:0]  hs_addr [$];
    logic [31:0] hs_data [$];

    task automatic model_step();
        bit hs;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_val = '0; m_err = 0; m_busy = 0; m_done = 0;
            m_addr = '0; m_data = '0; m_n = 0;
        end else begin
            hs     = m_busy && out_ready;
            m_done = 0;
            if (wr_en) begin
                if (m_val[wr_addr] && !(hs && wr_addr == m_addr)) m_err = 1;
                m_mem[wr_addr] = wr_data;
            end
            if (hs)    m_val[m_addr]  = 1'b0;
            if (wr_en) m_val[wr_addr] = 1'b1;
            if (!m_busy && drain_start) begin
                m_n    = (drain_count == 0) ? 16 : int'(drain_count);
                m_addr = '0;
                m_data = m_mem[0];
                m_busy = 1;
            end else if (hs) begin
                if (int'(m_addr) == m_n - 1) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_addr = m_addr + 4'd1;
                    m_data = m_mem[m_addr];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #2;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("overwrite_err", 32'(overwrite_err), 32'(m_err));
            chk("entry_valid", 32'(entry_valid), 32'(m_val));
            if (m_busy) begin
                chk("out_data", out_data, m_data);
                chk("out_addr", 32'(out_addr), 32'(m_addr));
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        #7;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_addr.push_back(out_addr);
            hs_data.push_back(out_data);
        end
    end

    task automatic clear_logs();
        hs_addr.delete();
        hs_data.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [4:0] n);
        drain_start = 1'b1; drain_count = n;
        @(negedge clk);
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp1 [4];
        exp1 = '{32'h0, 32'h0, 32'h0, 32'h3F800000};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        drain_start = 1'b0; drain_count = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_entry_valid", 32'(entry_valid), 32'd0);
        chk("rst_overwrite_err", 32'(overwrite_err), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);

        // Single write then drain of 4 entries
        wr(4'd3, 32'h3F800000);
        chk("t1_entry_valid", 32'(entry_valid), 32'h0008);
        clear_logs();
        out_ready = 1'b1;
        start(5'd4);
        wait_done(10);
        chk("t1_hs_count", 32'(hs_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_addr.size(); i++) begin
            chk("t1_hs_addr", 32'(hs_addr[i]), 32'(i));
            chk("t1_hs_data", hs_data[i], exp1[i]);
        end
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("t1_entry_valid_after", 32'(entry_valid), 32'd0);
        @(negedge clk);
        chk("t1_done_count", 32'(done_cnt), 32'd1);

        // Full-depth drain with drain_count = 0
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr(4'(i), 32'hA5000000 + 32'(i));
        chk("t2_entry_valid", 32'(entry_valid), 32'hFFFF);
        clear_logs();
        out_ready = 1'b1;
        start(5'd0);
        wait_done(20);
        chk("t2_hs_count", 32'(hs_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < hs_addr.size(); i++) begin
            chk("t2_hs_addr", 32'(hs_addr[i]), 32'(i));
            chk("t2_hs_data", hs_data[i], 32'hA5000000 + 32'(i));
        end
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("t2_entry_valid_after", 32'(entry_valid), 32'd0);
        @(negedge clk);
        chk("t2_done_count", 32'(done_cnt), 32'd1);

        // Back-pressure: ready pattern 1,0,0,1,1
        clear_logs();
        out_ready = 1'b0;
        start(5'd3);
        out_ready = 1'b1; @(negedge clk);
        out_ready = 1'b0; @(negedge clk);
        chk("t3_stall_addr", 32'(out_addr), 32'd1);
        @(negedge clk);
        chk("t3_stall_data", out_data, 32'hA5000001);
        out_ready = 1'b1; @(negedge clk);
        out_ready = 1'b1; @(negedge clk);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_hs_count", 32'(hs_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < hs_data.size(); i++)
            chk("t3_hs_data", hs_data[i], 32'hA5000000 + 32'(i));
        @(negedge clk);
        chk("t3_done_count", 32'(done_cnt), 32'd1);

        // Overwrite error is sticky until reset
        out_ready = 1'b0;
        wr(4'd5, 32'h1);
        wr(4'd5, 32'h2);
        chk("t4_err_set", 32'(overwrite_err), 32'd1);
        out_ready = 1'b1;
        start(5'd2);
        wait_done(10);
        chk("t4_err_kept", 32'(overwrite_err), 32'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("t4_err_cleared", 32'(overwrite_err), 32'd0);

        // Bypass on drain start, and drain_start ignored while busy
        clear_logs();
        out_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h40000000;
        drain_start = 1'b1; drain_count = 5'd3;
        @(negedge clk);
        wr_en = 1'b0; drain_start = 1'b0;
        chk("t5_bypass_data", out_data, 32'h40000000);
        chk("t5_bypass_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        drain_start = 1'b1; drain_count = 5'd8;
        @(negedge clk);
        drain_start = 1'b0;
        wait_done(10);
        chk("t5_hs_count", 32'(hs_addr.size()), 32'd3);
        if (hs_data.size() > 0) chk("t5_first_word", hs_data[0], 32'h40000000);
        @(negedge clk);
        chk("t5_done_count", 32'(done_cnt), 32'd1);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        wr(4'd1, 32'h11);
        wr(4'd2, 32'h22);
        clear_logs();
        out_ready = 1'b1;
        start(5'd5);
        repeat (2) @(negedge clk);
        chk("t6_at_word2", 32'(out_addr), 32'd2);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_entry_valid", 32'(entry_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'd0);

        // Write to the presented entry during its handshake: set wins over clear
        out_ready = 1'b0;
        wr(4'd1, 32'h1111);
        clear_logs();
        out_ready = 1'b1;
        start(5'd2);
        @(negedge clk);
        wr(4'd1, 32'h2222);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_entry_valid", 32'(entry_valid), 32'h0002);
        chk("t7_no_err", 32'(overwrite_err), 32'd0);
        if (hs_data.size() > 1) chk("t7_presented_word", hs_data[1], 32'h1111);
        chk("t7_hs_count", 32'(hs_addr.size()), 32'd2);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
